uart_packet_tx: RTL
===================

Name: uart_packet_tx

Overview:
Hardware packet framer that turns an opcode plus N payload words into the UART-ALU byte stream. The stream is: opcode, 0x00, length LSB, length MSB, then each word MSB-first.
Its byte-wide AXI-stream output feeds uart_tx's s_axis port directly. It replaces software/bench byte sequencing on the FPGA-side packet source.
It adds three things: parametrised word width, a buffered payload FIFO, and full-throughput backpressure handling.

Parameters:
WORD_BYTES_P, 4, bytes per payload word (1..8); word width = 8*WORD_BYTES_P
FIFO_DEPTH_P, 16, payload word FIFO depth (power of 2, >=2)
MAX_WORDS_P, 255, largest legal word count; elaboration error if 4+MAX_WORDS_P*WORD_BYTES_P > 65535

Ports:
clk_i  in  1  clock (PLL clock domain)
rst_ni  in  1  synchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_opcode_i  in  8  packet opcode
cmd_words_i  in  $clog2(MAX_WORDS_P+1)+1  payload word count N
word_valid_i  in  1  payload word valid
word_ready_o  out  1  high when FIFO not full
word_data_i  in  8*WORD_BYTES_P  payload word
m_axis_tdata_o  out  8  byte to uart_tx
m_axis_tvalid_o  out  1  byte valid
m_axis_tready_i  in  1  uart_tx ready
busy_o  out  1  packet in progress
done_o  out  1  one-cycle pulse after last byte transfers
err_o  out  1  one-cycle pulse when command rejected (N > MAX_WORDS_P)

Behaviour:
- Reset (rst_ni=0 at clk_i edge):
  - State -> IDLE; FIFO emptied; counters cleared.
  - m_axis_tvalid_o=0, m_axis_tdata_o=0, busy_o=0, done_o=0, err_o=0.
  - cmd_ready_o=0 during reset, 1 after. word_ready_o=0 during reset.
  - Reset mid-packet aborts; no partial bytes follow.
- FIFO:
  - Accepts words independently of the command path; words may arrive before or after the command.
  - Push when word_valid_i & word_ready_o. Pop only in PAYLOAD, on the last byte of the current word.
  - Simultaneous push and pop when full is legal: word_ready_o is computed from the registered full flag, so the push is refused that cycle.
- States: IDLE, HDR, PAYLOAD.
  - IDLE: cmd_ready_o=1. On accept with N<=MAX_WORDS_P: latch opcode, N, len=4+N*WORD_BYTES_P (16 bit). Go to HDR with byte index 0; tvalid rises the next cycle.
  - IDLE, N>MAX_WORDS_P: command consumed, err_o pulses next cycle, stay IDLE, no bytes sent.
  - HDR: bytes in order opcode, 0x00, len[7:0], len[15:8]. Advance on tvalid&tready.
  - After byte 3: go to PAYLOAD if N>0; else return to IDLE and pulse done_o.
  - PAYLOAD: tvalid = FIFO non-empty. Bytes go MSB-first from the FIFO head word.
  - PAYLOAD advance: after WORD_BYTES_P transfers, pop and decrement the remaining-word count. When it reaches 0, go to IDLE and pulse done_o.
  - FIFO empty mid-packet: tvalid deasserts and the packet stalls indefinitely. There is no timeout.
- AXI rules:
  - Once tvalid=1, tdata stays stable and tvalid stays high until a transfer. The only exception is reset.
  - No combinational path from tready_i to tvalid_o.
  - With tready held high, one byte per cycle.
- Latency and throughput:
  - Command accept at cycle T -> first byte valid at T+1.
  - Total packet = 4+N*WORD_BYTES_P transfer cycles.
  - cmd_ready_o returns in the cycle after done_o; back-to-back packets have a 1-cycle gap.
- busy_o: high from the cycle after command accept through the cycle of the final transfer.

Decomposition:
- uart_alu_pkg holds:
  - header constants HDR_BYTES=4, HDR_RESERVED=8'h00
  - opcode localparams shared with the ALU decoder
  - state enum state_e {IDLE,HDR,PAYLOAD}
- One sub-module: fifo_sync (WIDTH, DEPTH, valid/ready both sides, registered full/empty).
  - uart_packet_tx instantiates it for the payload words.

Test Plan:
- Basic packet, defaults, tready=1: opcode 0xA0, words 0x00000001, 0x00000002 -> bytes A0 00 0C 00 00 00 00 01 00 00 00 02 on consecutive cycles; done_o pulses once.
- Zero payload: opcode 0x5A, N=0 -> bytes 5A 00 04 00 only; done_o pulses; FIFO untouched.
- Backpressure: toggle tready randomly during a 3-word packet of 0xDEADBEEF, 0x01234567, 0x89ABCDEF.
  - Byte order is unchanged.
  - tdata is held stable while tvalid=1 and tready=0.
  - Exactly 16 transfers.
- FIFO starvation and wide words: WORD_BYTES_P=2, command N=2 before any word; second word 0xBEEF delayed 20 cycles.
  - tvalid=0 during the gap.
  - Stream is 11 00 08 00 CA FE BE EF for opcode 0x11, words 0xCAFE, 0xBEEF.
- Reject and full: N=MAX_WORDS_P+1 -> err_o pulse, no tvalid. Push FIFO_DEPTH_P words with no command -> word_ready_o=0 on the next attempt.
- Reset mid-packet: assert rst_ni=0 after the 6th byte of the basic packet.
  - Next cycle: tvalid=0, busy_o=0.
  - A new command then produces a clean header starting with its opcode.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared constants for the UART-ALU packet format: header layout, opcodes
// understood by the ALU decoder, and the packet framer state encoding.
package uart_alu_pkg;

  localparam int         HDR_BYTES    = 4;
  localparam logic [7:0] HDR_RESERVED = 8'h00;

  localparam logic [7:0] OP_ECHO  = 8'h5A;
  localparam logic [7:0] OP_ADD32 = 8'hA0;
  localparam logic [7:0] OP_MUL32 = 8'hA1;
  localparam logic [7:0] OP_DIV32 = 8'hA2;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } state_e;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with valid/ready on both sides; full/empty are registered
// so the upstream ready never depends on the same-cycle pop.
module fifo_sync #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             push, pop;

  assign s_ready_o = rst_ni & ~full_q;
  assign m_valid_o = ~empty_q;
  assign m_data_o  = mem_q[rd_ptr_q];
  assign push      = s_valid_i & s_ready_o;
  assign pop       = m_ready_i & ~empty_q;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= s_data_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full_d   = full_q;
    empty_d  = empty_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop) begin
      empty_d = 1'b0;
      full_d  = (wr_ptr_d == rd_ptr_q);
    end else if (pop && !push) begin
      full_d  = 1'b0;
      empty_d = (rd_ptr_d == wr_ptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

endmodule

// File: rtl/uart_packet_tx.sv
// Frames an opcode plus N buffered payload words into the UART-ALU byte
// stream (opcode, 0x00, len LSB, len MSB, words MSB-first) on a byte AXI-stream.
module uart_packet_tx
  import uart_alu_pkg::*;
#(
  parameter int  WORD_BYTES_P = 4,
  parameter int  FIFO_DEPTH_P = 16,
  parameter int  MAX_WORDS_P  = 255,
  localparam int CNT_W        = $clog2(MAX_WORDS_P + 1) + 1,
  localparam int WORD_W       = 8 * WORD_BYTES_P
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [7:0]        cmd_opcode_i,
  input  logic [CNT_W-1:0]  cmd_words_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  input  logic [WORD_W-1:0] word_data_i,
  output logic [7:0]        m_axis_tdata_o,
  output logic              m_axis_tvalid_o,
  input  logic              m_axis_tready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  if (WORD_BYTES_P < 1 || WORD_BYTES_P > 8) begin : g_bad_word_bytes
    $error("uart_packet_tx: WORD_BYTES_P must be 1..8");
  end
  if (HDR_BYTES + MAX_WORDS_P * WORD_BYTES_P > 65535) begin : g_bad_max_len
    $error("uart_packet_tx: largest packet does not fit a 16-bit length");
  end

  localparam logic [2:0] LAST_IDX = 3'(WORD_BYTES_P - 1);

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   words_q, words_d;
  logic [7:0]         opcode_q, opcode_d;
  logic [15:0]        len_q, len_d;
  logic               done_q, done_d, err_q, err_d;
  logic               fifo_valid, fifo_pop, cmd_ready, tvalid;
  logic [WORD_W-1:0]  fifo_head;
  logic [7:0]         tdata, payload_byte;

  fifo_sync #(
    .WIDTH(WORD_W),
    .DEPTH(FIFO_DEPTH_P)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .s_valid_i(word_valid_i),
    .s_ready_o(word_ready_o),
    .s_data_i (word_data_i),
    .m_valid_o(fifo_valid),
    .m_ready_i(fifo_pop),
    .m_data_o (fifo_head)
  );

  // Byte index 0 is the most significant byte of the head word.
  always_comb begin
    payload_byte = 8'h00;
    for (int i = 0; i < WORD_BYTES_P; i++) begin
      if (idx_q == 3'(WORD_BYTES_P - 1 - i)) payload_byte = fifo_head[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    words_d   = words_q;
    opcode_d  = opcode_q;
    len_d     = len_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    fifo_pop  = 1'b0;
    cmd_ready = 1'b0;
    tvalid    = 1'b0;
    tdata     = 8'h00;
    unique case (state_q)
      IDLE: begin
        // Held off during the done pulse so packets are separated by one cycle.
        cmd_ready = rst_ni & ~done_q;
        if (cmd_valid_i && cmd_ready) begin
          if (cmd_words_i > CNT_W'(MAX_WORDS_P)) begin
            err_d = 1'b1;
          end else begin
            opcode_d = cmd_opcode_i;
            words_d  = cmd_words_i;
            len_d    = 16'(HDR_BYTES) + 16'(cmd_words_i) * 16'(WORD_BYTES_P);
            idx_d    = 3'd0;
            state_d  = HDR;
          end
        end
      end
      HDR: begin
        tvalid = 1'b1;
        case (idx_q)
          3'd0:    tdata = opcode_q;
          3'd1:    tdata = HDR_RESERVED;
          3'd2:    tdata = len_q[7:0];
          default: tdata = len_q[15:8];
        endcase
        if (m_axis_tready_i) begin
          if (idx_q == 3'(HDR_BYTES - 1)) begin
            idx_d = 3'd0;
            if (words_q == '0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = PAYLOAD;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      PAYLOAD: begin
        tvalid = fifo_valid;
        tdata  = fifo_valid ? payload_byte : 8'h00;
        if (fifo_valid && m_axis_tready_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d    = 3'd0;
            fifo_pop = 1'b1;
            words_d  = words_q - CNT_W'(1);
            if (words_q == CNT_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      words_q  <= '0;
      opcode_q <= 8'h00;
      len_q    <= 16'h0000;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      words_q  <= words_d;
      opcode_q <= opcode_d;
      len_q    <= len_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready_o     = cmd_ready;
  assign m_axis_tvalid_o = tvalid;
  assign m_axis_tdata_o  = tdata;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = done_q;
  assign err_o           = err_q;

endmodule
